lisp_heap_sweeper: RTL and testbench

//  Sweep phase of the mark-and-sweep collector; the reclaiming end of the cons allocator.

---
 rtl/lisp_heap_sweeper.sv | 132 +++++++++++++
 tb/tb_lisp_heap_sweeper.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lisp_heap_sweeper.sv
// Sweep phase of the mark-and-sweep collector.
// Walks every heap cell once: marked cells get their mark cleared; unmarked
// cells are rewritten as free cells and pushed onto a rebuilt LIFO free list.
// obj_t layout: [72] gc, [71:36] car {type[3:0], data[31:0]}, [35:0] cdr.
module lisp_heap_sweeper #(
  parameter logic [31:0] HEAP_BASE  = 32'h0000_0000,
  parameter int unsigned HEAP_CELLS = 1024,
  parameter logic [31:0] NIL_ADDR   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        mem_ready,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  input  logic [72:0] mem_rdata,
  output logic [72:0] mem_wdata,
  output logic [31:0] free_head,
  output logic [31:0] free_count
);

  localparam logic [3:0]  TYPE_PRIMITIVE = 4'h1;
  localparam logic [3:0]  TYPE_CONS      = 4'h2;
  localparam logic [31:0] FREE_FILL      = 32'hAFAF_AFAF;
  localparam logic [31:0] LAST_ADDR      = HEAP_BASE + 32'(HEAP_CELLS) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cur;
  logic [72:0] r_obj;
  logic [31:0] r_free_head;
  logic [31:0] r_free_count;
  logic [72:0] w_wdata;
  logic        w_marked;

  assign w_marked   = r_obj[72];
  assign free_head  = r_free_head;
  assign free_count = r_free_count;

  // Rewritten cell: marked keeps car/cdr and drops the mark; unmarked becomes a free cell
  always_comb begin
    w_wdata = '0;
    if (w_marked) begin
      w_wdata = {1'b0, r_obj[71:0]};
    end else begin
      w_wdata = {1'b0, TYPE_PRIMITIVE, FREE_FILL, TYPE_CONS, r_free_head};
    end
  end

  // Next-state and output decode; requests are pure state decodes so they hold until accepted
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RD;
      end
      S_RD: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = r_cur;
        if (mem_ready) w_next = S_CAP;
      end
      S_CAP: begin
        busy   = 1'b1;
        w_next = S_WR;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = r_cur;
        mem_wdata = w_wdata;
        if (mem_ready) w_next = (r_cur == LAST_ADDR) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, cursor, captured cell and free-list bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur        <= HEAP_BASE;
      r_obj        <= '0;
      r_free_head  <= NIL_ADDR;
      r_free_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur        <= HEAP_BASE;
            r_free_head  <= NIL_ADDR;
            r_free_count <= '0;
          end
        end
        S_CAP: r_obj <= mem_rdata;
        S_WR: begin
          if (mem_ready) begin
            if (!w_marked) begin
              r_free_head  <= r_cur;
              r_free_count <= r_free_count + 32'd1;
            end
            if (r_cur != LAST_ADDR) r_cur <= r_cur + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lisp_heap_sweeper.sv
// Bench for lisp_heap_sweeper: 4-cell heap at 0x100 backed by a behavioural RAM.
// Expected write stream is queued when a sweep is launched and popped as the
// RAM accepts each write.
module tb_lisp_heap_sweeper;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          CELLS = 4;
  localparam logic [31:0] NIL   = 32'hFFFF_FFFF;
  localparam logic [3:0]  T_PRIM = 4'h1;
  localparam logic [3:0]  T_CONS = 4'h2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic        mem_ready = 1'b1;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr;
  logic [72:0] mem_rdata = '0;
  logic [72:0] mem_wdata;
  logic [31:0] free_head, free_count;

  lisp_heap_sweeper #(
    .HEAP_BASE (BASE),
    .HEAP_CELLS(CELLS),
    .NIL_ADDR  (NIL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_ready (mem_ready),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .free_head (free_head),
    .free_count(free_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  logic [72:0] mem [CELLS];
  logic [72:0] exp_data [$];
  logic [31:0] exp_addr [$];

  logic        prev_req = 1'b0;
  logic        prev_rd = 1'b0;
  logic        prev_ready = 1'b1;
  logic [31:0] prev_addr = '0;
  logic [72:0] prev_wdata = '0;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return int'(d[1:0]);
  endfunction

  // Behavioural RAM plus handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_rd_en || mem_wr_en) begin
      chk("rd_wr_exclusive", {72'b0, mem_rd_en & mem_wr_en}, 73'd0);
      chk("addr_in_heap", {72'b0, (mem_addr >= BASE) && (mem_addr < BASE + CELLS)}, 73'd1);
    end
    if (prev_req && !prev_ready) begin
      chk("hold_req", {71'b0, mem_rd_en, mem_wr_en}, {71'b0, prev_rd, ~prev_rd});
      chk("hold_addr", {41'b0, mem_addr}, {41'b0, prev_addr});
      chk("hold_wdata", mem_wdata, prev_wdata);
    end
    if (mem_ready && mem_rd_en) mem_rdata = mem[idx(mem_addr)];
    if (mem_ready && mem_wr_en) begin
      wr_cnt++;
      if (exp_data.size() == 0) begin
        chk("unexpected_write", {41'b0, mem_addr}, {41'b0, NIL});
      end else begin
        chk("wr_addr", {41'b0, mem_addr}, {41'b0, exp_addr.pop_front()});
        chk("wr_data", mem_wdata, exp_data.pop_front());
      end
      mem[idx(mem_addr)] = mem_wdata;
    end
    prev_req   = mem_rd_en | mem_wr_en;
    prev_rd    = mem_rd_en;
    prev_ready = mem_ready;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  // Fill the heap from a gc pattern and queue the write stream a correct sweep produces
  task automatic load_heap(input logic [3:0] gc);
    logic [31:0] head;
    head = NIL;
    exp_data.delete();
    exp_addr.delete();
    for (int i = 0; i < CELLS; i++) begin
      mem[i] = {gc[i], 4'($urandom), $urandom, 4'($urandom), $urandom};
      exp_addr.push_back(BASE + 32'(i));
      if (gc[i]) begin
        exp_data.push_back({1'b0, mem[i][71:0]});
      end else begin
        exp_data.push_back({1'b0, T_PRIM, 32'hAFAF_AFAF, T_CONS, head});
        head = BASE + 32'(i);
      end
    end
  endtask

  task automatic run_sweep(input string tag, input logic [3:0] gc, input logic [31:0] eh,
                           input int ec, input int ecyc, input bit stall, input bit poke);
    int done_at, dn, sc;
    bit srd, swr;
    done_at = 0; dn = 0; sc = 0; srd = 0; swr = 0;
    load_heap(gc);
    wr_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_busy_on_start"}, {72'b0, busy}, 73'd1);
    for (int n = 1; n <= 200; n++) begin
      if (stall) begin
        if (sc > 0) begin
          mem_ready = 1'b0;
          sc--;
        end else begin
          mem_ready = 1'b1;
          if (!srd && mem_rd_en && mem_addr == BASE + 1) begin
            mem_ready = 1'b0; sc = 4; srd = 1;
          end else if (!swr && mem_wr_en && mem_addr == BASE + 2) begin
            mem_ready = 1'b0; sc = 4; swr = 1;
          end
        end
      end
      start = (poke && (n == 5 || n == 6)) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (done) begin
        dn++;
        if (done_at == 0) done_at = n;
      end
      if (done_at != 0 && n >= done_at + 5) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    mem_ready = 1'b1;
    chk({tag, "_done_seen"}, {72'b0, done_at != 0}, 73'd1);
    if (ecyc != 0) chk({tag, "_done_cycle"}, 73'(done_at), 73'(ecyc));
    chk({tag, "_done_pulses"}, 73'(dn), 73'd1);
    chk({tag, "_write_count"}, 73'(wr_cnt), 73'(CELLS));
    chk({tag, "_queue_empty"}, 73'(exp_data.size()), 73'd0);
    chk({tag, "_free_head"}, {41'b0, free_head}, {41'b0, eh});
    chk({tag, "_free_count"}, {41'b0, free_count}, 73'(ec));
    chk({tag, "_idle_after"}, {70'b0, busy, mem_rd_en, mem_wr_en}, 73'd0);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  gc;
    logic [31:0] head;
    int          count;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int   seen;
    vecs[0] = '{"t1_mixed",    4'b0101, BASE + 3, 2};
    vecs[1] = '{"t2_all_mark", 4'b1111, NIL,      0};
    vecs[2] = '{"t3_all_free", 4'b0000, BASE + 3, 4};
    vecs[3] = '{"low_only",    4'b1110, BASE,     1};
    vecs[4] = '{"high_only",   4'b0111, BASE + 3, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {70'b0, busy, done, mem_rd_en}, 73'd0);
    chk("rst_wr_en", {72'b0, mem_wr_en}, 73'd0);
    chk("rst_addr", {41'b0, mem_addr}, 73'd0);
    chk("rst_wdata", mem_wdata, 73'd0);
    chk("rst_free_head", {41'b0, free_head}, {41'b0, NIL});
    chk("rst_free_count", {41'b0, free_count}, 73'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_sweep(vecs[i].name, vecs[i].gc, vecs[i].head, vecs[i].count, 13, 1'b0, 1'b0);

    // T1 chain detail: lowest freed cell terminates with NIL, next links back to it
    run_sweep("t1_links", 4'b0101, BASE + 3, 2, 13, 1'b0, 1'b0);
    chk("t1_cell1_cdr", {41'b0, mem[1][31:0]}, {41'b0, NIL});
    chk("t1_cell3_cdr", {41'b0, mem[3][31:0]}, {41'b0, BASE + 1});
    chk("t1_cell0_gc", {72'b0, mem[0][72]}, 73'd0);

    // T4: ready low for 5 cycles in a read and in a write
    run_sweep("t4_stall", 4'b0101, BASE + 3, 2, 23, 1'b1, 1'b0);

    // T6: start pulsed mid-sweep is ignored
    run_sweep("t6_poke", 4'b0101, BASE + 3, 2, 13, 1'b0, 1'b1);

    // T5: reset during the write of cell 2 aborts the sweep
    load_heap(4'b0101);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      if (mem_wr_en && mem_addr == BASE + 2) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t5_reached_wr2", 73'(seen), 73'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t5_idle", {70'b0, busy, mem_rd_en, mem_wr_en}, 73'd0);
    chk("t5_free_head", {41'b0, free_head}, {41'b0, NIL});
    chk("t5_free_count", {41'b0, free_count}, 73'd0);
    wr_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_requests", 73'(wr_cnt), 73'd0);
    chk("t5_still_idle", {71'b0, busy, done}, 73'd0);
    run_sweep("t5_restart", 4'b1001, BASE + 2, 2, 13, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
